// File: rtl/countdown_timer.sv
// countdown_timer
//
// Loadable, pausable down-counter with a programmable prescaler. Used by the
// game FSMs for song-start countdowns, note-window timeouts and periodic beat
// ticks. A count step happens every prescale+1 clock cycles while running.
//
// Ports:
//   clock        system clock, all logic on its rising edge
//   reset_n      asynchronous, active-low reset
//   load         synchronous load strobe (highest priority)
//   load_value   value captured on load; also becomes the reload value
//   prescale     a count step occurs every prescale+1 clock cycles
//   start        start from IDLE or EXPIRED; resume from PAUSED
//   pause        freeze while in RUN
//   auto_reload  on expiry, reload and keep running instead of stopping
//   q            current count
//   tick         one-cycle pulse on every decrement
//   done         one-cycle pulse when the count expires
//   running      high while in RUN
//   expired      high while in EXPIRED

module countdown_timer #(
  parameter int WIDTH          = 8,
  parameter int PRESCALE_WIDTH = 26
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      load,
  input  logic [WIDTH-1:0]          load_value,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      start,
  input  logic                      pause,
  input  logic                      auto_reload,
  output logic [WIDTH-1:0]          q,
  output logic                      tick,
  output logic                      done,
  output logic                      running,
  output logic                      expired
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [WIDTH-1:0]          q_next;
  logic [WIDTH-1:0]          reload_reg;
  logic [WIDTH-1:0]          reload_next;
  logic [PRESCALE_WIDTH-1:0] pc;
  logic [PRESCALE_WIDTH-1:0] pc_next;
  logic                      tick_next;
  logic                      done_next;

  // State, count, reload value, prescaler and the registered pulses all
  // update together; reset clears everything immediately, aborting any
  // countdown in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      q          <= '0;
      reload_reg <= '0;
      pc         <= '0;
      tick       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      q          <= q_next;
      reload_reg <= reload_next;
      pc         <= pc_next;
      tick       <= tick_next;
      done       <= done_next;
    end
  end

  // Next-state logic. Priority is load > pause > start > prescaler step, so
  // a load silently swallows any start, pause or terminal step that lands
  // in the same cycle.
  always_comb begin
    state_next  = state;
    q_next      = q;
    reload_next = reload_reg;
    pc_next     = pc;
    tick_next   = 1'b0;
    done_next   = 1'b0;

    if (load) begin
      q_next      = load_value;
      reload_next = load_value;
      pc_next     = '0;
      state_next  = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && (q != '0)) begin
            state_next = RUN;
            pc_next    = '0;
          end
        end

        RUN: begin
          if (pause) begin
            state_next = PAUSED;
          end else if (q == '0) begin
            // Cannot normally happen; park in EXPIRED rather than wrap.
            state_next = EXPIRED;
          end else if (pc >= prescale) begin
            // >= rather than == so a prescale shrunk mid-run cannot strand
            // the prescaler above the new terminal value.
            pc_next   = '0;
            tick_next = 1'b1;
            if (q == WIDTH'(1)) begin
              done_next = 1'b1;
              if (auto_reload && (reload_reg != '0)) begin
                q_next = reload_reg;
              end else begin
                q_next     = '0;
                state_next = EXPIRED;
              end
            end else begin
              q_next = q - WIDTH'(1);
            end
          end else begin
            pc_next = pc + PRESCALE_WIDTH'(1);
          end
        end

        PAUSED: begin
          // Resume keeps the held prescaler phase.
          if (start && !pause) begin
            state_next = RUN;
          end
        end

        EXPIRED: begin
          if (start && (reload_reg != '0)) begin
            q_next     = reload_reg;
            pc_next    = '0;
            state_next = RUN;
          end
        end

        default: state_next = IDLE;
      endcase
    end
  end

  assign running = (state == RUN);
  assign expired = (state == EXPIRED);

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer
//
// Self-checking bench for countdown_timer: directed scenarios followed by a
// randomized run, all compared cycle by cycle against a behavioural model.

module tb_countdown_timer;

  localparam int W  = 8;
  localparam int PW = 26;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          load;
  logic [W-1:0]  load_value;
  logic [PW-1:0] prescale;
  logic          start;
  logic          pause;
  logic          auto_reload;
  logic [W-1:0]  q;
  logic          tick;
  logic          done;
  logic          running;
  logic          expired;

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode name, count, reload value and cycles elapsed
  // since the last step.
  string m_mode;
  int    m_q;
  int    m_reload;
  int    m_elapsed;
  bit    m_tick;
  bit    m_done;

  countdown_timer #(.WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .load        (load),
    .load_value  (load_value),
    .prescale    (prescale),
    .start       (start),
    .pause       (pause),
    .auto_reload (auto_reload),
    .q           (q),
    .tick        (tick),
    .done        (done),
    .running     (running),
    .expired     (expired)
  );

  // 100 MHz bench clock; rising edges at 5, 15, 25, ...
  always #5 clock = ~clock;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_mode    = "IDLE";
    m_q       = 0;
    m_reload  = 0;
    m_elapsed = 0;
    m_tick    = 0;
    m_done    = 0;
  endtask

  // One clock cycle of the timer's documented behaviour.
  task automatic modelStep(input bit ld, input int lv, input int ps,
                           input bit st, input bit pz, input bit ar);
    m_tick = 0;
    m_done = 0;
    if (ld) begin
      m_q       = lv;
      m_reload  = lv;
      m_elapsed = 0;
      m_mode    = "IDLE";
    end else if (m_mode == "IDLE") begin
      if (st && m_q != 0) begin
        m_mode    = "RUN";
        m_elapsed = 0;
      end
    end else if (m_mode == "RUN") begin
      if (pz) begin
        m_mode = "PAUSED";
      end else if (m_elapsed < ps) begin
        m_elapsed++;
      end else begin
        m_elapsed = 0;
        m_tick    = 1;
        m_q       = m_q - 1;
        if (m_q == 0) begin
          m_done = 1;
          if (ar && m_reload != 0) m_q = m_reload;
          else m_mode = "EXPIRED";
        end
      end
    end else if (m_mode == "PAUSED") begin
      if (st && !pz) m_mode = "RUN";
    end else begin
      if (st && m_reload != 0) begin
        m_q       = m_reload;
        m_elapsed = 0;
        m_mode    = "RUN";
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("q",       32'(q),       32'(m_q));
    checkOutput("tick",    32'(tick),    32'(m_tick));
    checkOutput("done",    32'(done),    32'(m_done));
    checkOutput("running", 32'(running), 32'(m_mode == "RUN"));
    checkOutput("expired", 32'(expired), 32'(m_mode == "EXPIRED"));
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare #1 later.
  task automatic applyStimulus(input bit ld, input int lv, input int ps,
                               input bit st, input bit pz, input bit ar);
    load        = ld;
    load_value  = lv[W-1:0];
    prescale    = ps[PW-1:0];
    start       = st;
    pause       = pz;
    auto_reload = ar;
    @(posedge clock);
    modelStep(ld, lv, ps, st, pz, ar);
    #1;
    compareAll();
  endtask

  // Asynchronous reset pulse landing between clock edges.
  task automatic pulseReset();
    reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset_q",       32'(q),       32'd0);
    checkOutput("async_reset_running", 32'(running), 32'd0);
    checkOutput("async_reset_tick",    32'(tick),    32'd0);
    checkOutput("async_reset_done",    32'(done),    32'd0);
    checkOutput("async_reset_expired", 32'(expired), 32'd0);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int tickCount;
    int doneCount;
    int firstTick;
    int ps;

    reset_n     = 1'b0;
    load        = 1'b0;
    load_value  = '0;
    prescale    = '0;
    start       = 1'b0;
    pause       = 1'b0;
    auto_reload = 1'b0;
    modelReset();
    #12;
    compareAll();
    reset_n = 1'b1;

    // Reset in the middle of RUN, then start is ignored with q==0.
    applyStimulus(1, 5, 3, 0, 0, 0);
    applyStimulus(0, 5, 3, 1, 0, 0);
    applyStimulus(0, 5, 3, 0, 0, 0);
    pulseReset();
    applyStimulus(0, 5, 3, 1, 0, 0);
    checkOutput("start_after_reset_running", 32'(running), 32'd0);

    // Count 3 -> 0 with a step every 2 cycles, no auto-reload.
    applyStimulus(1, 3, 1, 0, 0, 0);
    applyStimulus(0, 3, 1, 1, 0, 0);
    tickCount = 0;
    doneCount = 0;
    firstTick = -1;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 3, 1, 0, 0, 0);
      if (tick) begin
        tickCount++;
        if (firstTick < 0) firstTick = i;
      end
      if (done) begin
        doneCount++;
        checkOutput("done_with_q_zero", 32'(q), 32'd0);
      end
    end
    checkOutput("basic_tick_count", 32'(tickCount), 32'd3);
    checkOutput("basic_done_count", 32'(doneCount), 32'd1);
    checkOutput("basic_first_tick", 32'(firstTick), 32'd2);
    checkOutput("basic_expired",    32'(expired),   32'd1);

    // Auto-reload with prescale 0: 2,1,2,1,... every cycle.
    applyStimulus(1, 2, 0, 0, 0, 1);
    applyStimulus(0, 2, 0, 1, 0, 1);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(0, 2, 0, 0, 0, 1);
      checkOutput("reload_seq_q",    32'(q),       (i % 2 == 1) ? 32'd1 : 32'd2);
      checkOutput("reload_seq_done", 32'(done),    (i % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("reload_running",  32'(running), 32'd1);
    end

    // Pause with pc=1 at prescale=3, resume, next tick 3 cycles later.
    applyStimulus(1, 9, 3, 0, 0, 0);
    applyStimulus(0, 9, 3, 1, 0, 0);
    applyStimulus(0, 9, 3, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 9, 3, (i == 2), 1, 0);
      checkOutput("pause_hold_q", 32'(q), 32'd9);
    end
    applyStimulus(0, 9, 3, 1, 0, 0);
    firstTick = -1;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 9, 3, 0, 0, 0);
      if (tick && firstTick < 0) firstTick = i;
    end
    checkOutput("resume_tick_delay", 32'(firstTick), 32'd3);

    // Load and start together mid-run: load wins.
    applyStimulus(1, 7, 3, 1, 0, 0);
    checkOutput("load_wins_q",       32'(q),       32'd7);
    checkOutput("load_wins_running", 32'(running), 32'd0);
    applyStimulus(0, 7, 3, 1, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 7, 3, 0, 0, 0);
    checkOutput("after_load_count_q", 32'(q), 32'd6);

    // Restart from EXPIRED with reload 4; load 0 makes start a no-op.
    applyStimulus(1, 4, 0, 0, 0, 0);
    applyStimulus(0, 4, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 4, 0, 0, 0, 0);
    checkOutput("expired_before_restart", 32'(expired), 32'd1);
    applyStimulus(0, 4, 0, 1, 0, 0);
    checkOutput("restart_q",       32'(q),       32'd4);
    checkOutput("restart_running", 32'(running), 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("zero_load_start_ignored", 32'(running), 32'd0);

    // Randomized run against the model.
    ps = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) ps = $urandom_range(0, 3);
      if ($urandom_range(0, 599) == 0) begin
        pulseReset();
      end
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 5), ps,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                    1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
